// File: rtl/host_spi_slave_if.sv
// rtl/host_spi_slave_if.sv - decoder-side byte stream, reply buffer and frame markers of host_spi_slave
`timescale 1ns/1ps
interface host_spi_slave_if #(
  parameter int CNT_W = 6
);
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_first;
  logic [CNT_W-1:0] byte_cnt;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             tx_underrun;
  logic             frame_start;
  logic             frame_end;
  logic             frame_abort;

  // SPI slave side: produces received bytes and markers, consumes replies
  modport master (
    output rx_data, rx_valid, rx_first, byte_cnt,
    output tx_ready, tx_underrun,
    output frame_start, frame_end, frame_abort,
    input  tx_data, tx_valid
  );

  // Decoder side
  modport slave (
    input  rx_data, rx_valid, rx_first, byte_cnt,
    input  tx_ready, tx_underrun,
    input  frame_start, frame_end, frame_abort,
    output tx_data, tx_valid
  );
endinterface

// File: rtl/host_spi_slave.sv
// rtl/host_spi_slave.sv - oversampled mode-3 byte SPI slave with one-entry reply buffer
`timescale 1ns/1ps
module host_spi_slave #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] TX_IDLE     = 8'h00,
  parameter int         CNT_W       = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ssclk,
  input  logic             scsn,
  input  logic             smosi,
  output logic             smiso,
  host_spi_slave_if.master dec
);

  typedef enum logic [0:0] {IDLE, SHIFT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] scsn_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] fill;
  logic                   sclk_d;
  logic                   scsn_d;
  logic                   seen_high;

  logic sclk_s, scsn_s, mosi_s, sync_ok;
  logic sclk_rise, scsn_rise, scsn_fall, frame_go;

  state_t           state;
  logic [2:0]       bit_cnt;
  logic [CNT_W-1:0] cnt;
  logic [6:0]       rx_shift;
  logic [7:0]       tx_shift;
  logic [7:0]       rx_data_r;
  logic             rx_valid_r;
  logic             rx_first_r;
  logic             under_r;
  logic             fs_r, fe_r, fa_r;
  logic             buf_full;
  logic [7:0]       buf_data;

  logic       tx_wr;
  logic       load;
  logic       under;
  logic [7:0] next_byte;

  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign scsn_s  = scsn_sync[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync[SYNC_STAGES-1];
  assign sync_ok = fill[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_d;
  assign scsn_rise = scsn_s & ~scsn_d;
  assign scsn_fall = ~scsn_s & scsn_d;
  // A frame already running at reset release is skipped until chip select is seen high
  assign frame_go  = scsn_fall & seen_high;

  // Synchronise the host pins; fill marks when the last stage holds a real sample
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sclk_sync <= '1;
      scsn_sync <= '1;
      mosi_sync <= '0;
      fill      <= '0;
      sclk_d    <= 1'b1;
      scsn_d    <= 1'b1;
      seen_high <= 1'b0;
    end else begin
      sclk_sync <= (sclk_sync << 1) | SYNC_STAGES'(ssclk);
      scsn_sync <= (scsn_sync << 1) | SYNC_STAGES'(scsn);
      mosi_sync <= (mosi_sync << 1) | SYNC_STAGES'(smosi);
      fill      <= (fill << 1) | SYNC_STAGES'(1);
      sclk_d    <= sclk_s;
      scsn_d    <= scsn_s;
      if (sync_ok && scsn_s) seen_high <= 1'b1;
    end
  end

  // Pick the next reply byte: buffered byte, else a same-cycle write, else the idle filler
  always_comb begin
    tx_wr     = dec.tx_valid & ~buf_full;
    next_byte = TX_IDLE;
    under     = 1'b0;
    if (buf_full)   next_byte = buf_data;
    else if (tx_wr) next_byte = dec.tx_data;
    else            under     = 1'b1;
    load = ((state == IDLE) && frame_go) ||
           ((state == SHIFT) && !scsn_rise && sclk_rise && (bit_cnt == 3'd7));
  end

  // Frame FSM, shift registers and reply buffer
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      cnt        <= '0;
      rx_shift   <= '0;
      tx_shift   <= 8'hFF;
      rx_data_r  <= '0;
      rx_valid_r <= 1'b0;
      rx_first_r <= 1'b0;
      under_r    <= 1'b0;
      fs_r       <= 1'b0;
      fe_r       <= 1'b0;
      fa_r       <= 1'b0;
      buf_full   <= 1'b0;
      buf_data   <= '0;
    end else begin
      rx_valid_r <= 1'b0;
      under_r    <= 1'b0;
      fs_r       <= 1'b0;
      fe_r       <= 1'b0;
      fa_r       <= 1'b0;

      unique case (state)
        IDLE: begin
          bit_cnt  <= '0;
          cnt      <= '0;
          tx_shift <= 8'hFF;
          if (frame_go) begin
            state <= SHIFT;
            fs_r  <= 1'b1;
          end
        end
        SHIFT: begin
          if (scsn_rise) begin
            // Chip select wins over a coincident clock edge; partial byte is dropped
            state    <= IDLE;
            fe_r     <= 1'b1;
            fa_r     <= (bit_cnt != 3'd0);
            bit_cnt  <= '0;
            tx_shift <= 8'hFF;
          end else if (sclk_rise) begin
            rx_shift <= {rx_shift[5:0], mosi_s};
            if (bit_cnt == 3'd7) begin
              bit_cnt    <= '0;
              rx_data_r  <= {rx_shift, mosi_s};
              rx_valid_r <= 1'b1;
              rx_first_r <= (cnt == '0);
              if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            end else begin
              bit_cnt  <= bit_cnt + 3'd1;
              tx_shift <= {tx_shift[6:0], 1'b1};
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (load) begin
        tx_shift <= next_byte;
        under_r  <= under;
        buf_full <= 1'b0;
      end else if (tx_wr) begin
        buf_full <= 1'b1;
        buf_data <= dec.tx_data;
      end

      if ((state == SHIFT) && scsn_rise) buf_full <= 1'b0;
    end
  end

  assign smiso           = tx_shift[7];
  assign dec.rx_data     = rx_data_r;
  assign dec.rx_valid    = rx_valid_r;
  assign dec.rx_first    = rx_first_r;
  assign dec.byte_cnt    = cnt;
  assign dec.tx_ready    = ~buf_full;
  assign dec.tx_underrun = under_r;
  assign dec.frame_start = fs_r;
  assign dec.frame_end   = fe_r;
  assign dec.frame_abort = fa_r;

endmodule

// File: tb/tb_host_spi_slave.sv
// tb/tb_host_spi_slave.sv - scoreboard bench for host_spi_slave
`timescale 1ns/1ps
module tb_host_spi_slave;

  logic clk = 1'b0;
  logic resetn;
  logic ssclk, scsn, smosi, smiso;

  always #8 clk = ~clk;

  host_spi_slave_if #(.CNT_W(6)) ifc ();

  host_spi_slave #(.SYNC_STAGES(2), .TX_IDLE(8'h00), .CNT_W(6)) dut (
    .clk    (clk),
    .resetn (resetn),
    .ssclk  (ssclk),
    .scsn   (scsn),
    .smosi  (smosi),
    .smiso  (smiso),
    .dec    (ifc.master)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       f;
    logic [5:0] c;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_rx, n_fs, n_fe, n_fa, n_fafe, n_under;

  logic [7:0] fb [0:31];
  logic [7:0] fm [0:31];
  logic       rep_en [0:31];
  logic [7:0] rep_d  [0:31];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string name);
    check(name, {smiso, ifc.tx_ready, ifc.rx_data, ifc.rx_valid, ifc.rx_first, ifc.byte_cnt,
                 ifc.tx_underrun, ifc.frame_start, ifc.frame_end, ifc.frame_abort},
          {1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0});
  endtask

  task automatic clear_counts();
    n_rx = 0; n_fs = 0; n_fe = 0; n_fa = 0; n_fafe = 0; n_under = 0;
    for (int i = 0; i < 32; i++) begin
      rep_en[i] = 1'b0;
      rep_d[i]  = 8'h00;
      fm[i]     = 8'h00;
    end
  endtask

  // Host side: mode 3, data set on falling edge, slave output sampled at rising edge
  task automatic spi_bits(input logic [7:0] mosi, input int nbits, output logic [7:0] miso);
    miso = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      ssclk = 1'b0;
      smosi = mosi[i];
      #30;
      miso[i] = smiso;
      ssclk = 1'b1;
      #30;
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  // Full frame of n bytes from fb[], expecting fm[] on smiso in each slot
  task automatic run_frame(input int n, input string name);
    logic [7:0] got;
    scsn = 1'b0;
    #100;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back('{d: fb[k], f: (k == 0), c: (k + 1 > 63) ? 6'd63 : 6'(k + 1)});
      spi_bits(fb[k], 8, got);
      check($sformatf("%s_miso%0d", name, k), got, fm[k]);
    end
    #100;
    @(negedge clk);
    check({name, "_byte_cnt"}, ifc.byte_cnt, n);
    scsn = 1'b1;
    #200;
    wait_drain({name, "_drain"});
  endtask

  // Monitor: pops the scoreboard on every rx_valid, tallies strobes
  always @(negedge clk) begin
    if (ifc.rx_valid) begin
      n_rx++;
      if (exp_q.size() == 0) begin
        check("rx_unexpected", {ifc.rx_data}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rx_data", ifc.rx_data, e.d);
        check("rx_first", ifc.rx_first, e.f);
        check("rx_byte_cnt", ifc.byte_cnt, e.c);
      end
    end
    if (ifc.frame_start) n_fs++;
    if (ifc.frame_end)   n_fe++;
    if (ifc.frame_abort) n_fa++;
    if (ifc.frame_abort && ifc.frame_end) n_fafe++;
    if (ifc.tx_underrun) n_under++;
  end

  // Decoder model: offers a planned reply once the indexed request byte arrives
  initial begin : decoder
    int   rx_idx;
    logic pend;
    logic [7:0] pdata;
    rx_idx = 0; pend = 1'b0; pdata = 8'h00;
    ifc.tx_valid = 1'b0;
    ifc.tx_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (ifc.tx_valid) ifc.tx_valid = 1'b0;
      if (ifc.frame_start) rx_idx = 0;
      if (ifc.rx_valid) begin
        if (rx_idx < 32 && rep_en[rx_idx]) begin
          pend  = 1'b1;
          pdata = rep_d[rx_idx];
        end
        rx_idx++;
      end
      if (pend && ifc.tx_ready && resetn) begin
        ifc.tx_valid = 1'b1;
        ifc.tx_data  = pdata;
        pend = 1'b0;
      end
    end
  end

  initial begin : stim
    logic [7:0] got;
    logic [7:0] setreg [0:16];
    setreg = '{8'h02, 8'h81, 8'h00, 8'h00, 8'h00, 8'h01, 8'h0A, 8'h0B,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    resetn = 1'b0; ssclk = 1'b1; scsn = 1'b1; smosi = 1'b0;
    clear_counts();
    repeat (4) @(negedge clk);
    check_reset_vals("reset_state");
    resetn = 1'b1;
    repeat (4) @(negedge clk);

    // set_reg frame with readback replies to the bytes after 0x01
    clear_counts();
    for (int k = 0; k < 17; k++) fb[k] = setreg[k];
    rep_en[6] = 1'b1; rep_d[6] = 8'hDE;
    rep_en[7] = 1'b1; rep_d[7] = 8'hAD;
    rep_en[8] = 1'b1; rep_d[8] = 8'hBE;
    rep_en[9] = 1'b1; rep_d[9] = 8'hEF;
    fm[8] = 8'hDE; fm[9] = 8'hAD; fm[10] = 8'hBE; fm[11] = 8'hEF;
    run_frame(17, "setreg");
    check("setreg_n_rx", n_rx, 17);
    check("setreg_fs", n_fs, 1);
    check("setreg_fe", n_fe, 1);
    check("setreg_fa", n_fa, 0);
    check("setreg_underrun", n_under, 14);
    check("setreg_idle_cnt", ifc.byte_cnt, 0);

    // Abort mid third byte with a reply still buffered
    clear_counts();
    rep_en[1] = 1'b1; rep_d[1] = 8'h55;
    scsn = 1'b0;
    #100;
    exp_q.push_back('{d: 8'h11, f: 1'b1, c: 6'd1});
    spi_bits(8'h11, 8, got);
    check("abort_miso0", got, 8'h00);
    exp_q.push_back('{d: 8'h22, f: 1'b0, c: 6'd2});
    spi_bits(8'h22, 8, got);
    check("abort_miso1", got, 8'h00);
    spi_bits(8'h33, 5, got);
    #60;
    @(negedge clk);
    check("abort_buf_full", ifc.tx_ready, 1'b0);
    scsn = 1'b1;
    #200;
    wait_drain("abort_drain");
    check("abort_n_rx", n_rx, 2);
    check("abort_fe", n_fe, 1);
    check("abort_fa", n_fa, 1);
    check("abort_same_cycle", n_fafe, 1);
    check("abort_underrun", n_under, 3);
    check("abort_tx_ready", ifc.tx_ready, 1'b1);

    // ssclk activity with chip select high
    clear_counts();
    spi_bits(8'hA5, 8, got);
    #100;
    @(negedge clk);
    check("csn_high_miso", got, 8'hFF);
    check("csn_high_n_rx", n_rx, 0);
    check("csn_high_byte_cnt", ifc.byte_cnt, 0);
    check("csn_high_fs", n_fs, 0);

    // Back-to-back frames
    clear_counts();
    fb[0] = 8'h01;
    run_frame(1, "b2b_a");
    fb[0] = 8'h02;
    run_frame(1, "b2b_b");
    check("b2b_fs", n_fs, 2);
    check("b2b_fe", n_fe, 2);
    check("b2b_n_rx", n_rx, 2);

    // Reset mid-frame with chip select held low
    clear_counts();
    scsn = 1'b0;
    #100;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back('{d: 8'(8'h40 + k), f: (k == 0), c: 6'(k + 1)});
      spi_bits(8'(8'h40 + k), 8, got);
    end
    #100;
    wait_drain("rst_pre_drain");
    @(negedge clk);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst_mid_in_reset");
    resetn = 1'b1;
    clear_counts();
    repeat (4) @(negedge clk);
    spi_bits(8'h5A, 8, got);
    #100;
    @(negedge clk);
    check("rst_mid_miso", got, 8'hFF);
    check_reset_vals("rst_mid_after");
    check("rst_mid_n_rx", n_rx, 0);
    check("rst_mid_fs", n_fs, 0);
    scsn = 1'b1;
    #200;
    check("rst_mid_fe", n_fe, 0);
    fb[0] = 8'hA5; fb[1] = 8'h3C;
    run_frame(2, "rst_recover");
    check("rst_recover_fs", n_fs, 1);
    check("rst_recover_n_rx", n_rx, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/host_spi_slave.md
Name: host_spi_slave

Overview:
- Byte-level SPI slave on the host port (ssclk/scsn/smosi/smiso), SPI mode 3: idle-high clock, MSB first.
- Oversamples the host SPI pins in the system clock domain and delivers received bytes with frame markers to the command/register decoder directly downstream.
- Shifts out reply bytes that the decoder supplies over a one-entry ready/valid buffer.

Parameters:
- SYNC_STAGES, 2: synchroniser depth for ssclk, scsn and smosi. All three use the same depth so data stays aligned with the clock edge.
- TX_IDLE, 8'h00: byte shifted out when no reply byte is pending.
- CNT_W, 6: width of the byte counter within a frame.

Ports:
- clk  in  1  system clock, 62.5 MHz nominal
- resetn  in  1  synchronous active-low reset
- ssclk  in  1  host SPI clock, async, idles high
- scsn  in  1  host chip select, async, active low
- smosi  in  1  host data in, async
- smiso  out  1  host data out
- rx_data  out  8  last received byte
- rx_valid  out  1  one-cycle strobe: rx_data is new
- rx_first  out  1  qualifies rx_valid: first byte of the frame
- byte_cnt  out  CNT_W  bytes completed in the current frame, saturating
- tx_data  in  8  next reply byte
- tx_valid  in  1  tx_data offered
- tx_ready  out  1  reply buffer empty
- tx_underrun  out  1  one-cycle strobe: TX_IDLE substituted for a missing reply byte
- frame_start  out  1  one-cycle strobe on synced scsn fall
- frame_end  out  1  one-cycle strobe on synced scsn rise
- frame_abort  out  1  one-cycle strobe with frame_end when the frame ended mid-byte

Behaviour:
- Synchronisers: reset values are ssclk=1, scsn=1, smosi=0. Edge detect compares the last sync stage with one extra register.
  - rise = sclk_s & ~sclk_d; fall is ignored.
  - Each ssclk level must be held for at least 1 clk period. A 30 ns half period at 16 ns clk is supported.
- Reset: all outputs are 0 except smiso=1 and tx_ready=1. State is IDLE, all counters are 0, and the buffer is empty. Reset mid-frame discards everything. After reset release, a frame already in progress is not entered until scsn is seen high and then low again.
- FSM state IDLE (scsn_s high):
  - bit_cnt=0, byte_cnt=0, smiso=1.
  - On the scsn_s fall edge: go to SHIFT, pulse frame_start, and load tx_shift with the buffer byte (buffer emptied) or with TX_IDLE (pulse tx_underrun).
- FSM state SHIFT (scsn_s low), on each rise:
  - rx_shift <= {rx_shift[6:0], smosi_s}; bit_cnt++.
  - tx_shift shifts left. smiso = tx_shift[7], so it updates right after each sampled rise and holds for the next rise.
- Byte boundary (rise with bit_cnt==7):
  - bit_cnt wraps to 0.
  - rx_data <= the completed byte, with rx_valid high on the next clk, exactly 1 cycle.
  - rx_first = (byte_cnt==0).
  - byte_cnt increments and saturates at 2^CNT_W-1.
  - tx_shift reloads from the buffer or TX_IDLE, with tx_underrun as above.
- Reply buffer:
  - A write occurs when tx_valid && tx_ready.
  - A write and a reload in the same cycle pass tx_data straight into tx_shift, and the buffer stays empty.
  - The decoder has from rx_valid until the next byte boundary to supply a byte, i.e. a reply lags its request by one byte.
- scsn_s rise edge:
  - Go to IDLE and pulse frame_end.
  - If bit_cnt != 0, also pulse frame_abort and discard the partial byte (no rx_valid).
  - Flush the reply buffer (tx_ready=1).
- Simultaneous events:
  - A scsn_s rise in the same cycle as an ssclk rise: the chip-select edge wins and the clock edge is ignored.
  - Clock edges while scsn_s is high are ignored.
  - A final-bit rise followed by scsn rise in a later cycle gives rx_valid first, then frame_end without abort.
- rx_data holds its value between strobes.

Test Plan:
- set_reg frame: 0x02, 0x81, 0x00, 0x00, 0x00, 0x01, 0x0A, 0x0B, then 9×0x00 at a 30 ns half period → 17 rx_valid strobes with matching bytes, rx_first only on 0x02, byte_cnt=17, frame_start/frame_end once each, no abort.
- Readback: the decoder answers the byte after 0x01 with 0xDE, 0xAD, 0xBE, 0xEF → the host samples those four bytes on smiso in the following byte slots, MSB first. All other slots carry TX_IDLE, and tx_underrun fires on each of them.
- Abort: scsn raised after 5 bits of the 3rd byte → 2 rx_valid strobes only, frame_end and frame_abort in the same cycle, tx_ready=1 afterwards.
- Back-to-back frames (first frame sends 0x01, second sends 0x02) separated by 200 ns of scsn high → byte_cnt restarts at 0 and rx_first fires once per frame.
- Reset mid-frame after 3 bytes, scsn held low → all outputs at reset values and no strobes until scsn toggles high→low. The next frame then decodes correctly.
- ssclk pulses while scsn is high → no rx_valid, byte_cnt=0, smiso stays 1.
